// File: rtl/edge_pkg.sv
// Shared types and constants for the edge_to_level block.
package edge_pkg;

    typedef enum logic [1:0] {
        LOW_IDLE  = 2'd0,
        HOLD_HIGH = 2'd1,
        HIGH_IDLE = 2'd2,
        HOLD_LOW  = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_HOLD_CYCLES = 10_000_000;
    localparam int unsigned CLK_FREQ_HZ         = 100_000_000;
    localparam int unsigned DEFAULT_CNT_W       = 24;

endpackage

// File: rtl/edge_to_level_hold_counter.sv
// Loadable down-counter that stops at zero and flags it.
module hold_counter #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/edge_to_level.sv
// Rebuilds a level from rise/fall strobes, holding each level for a minimum time.
// Optional EDGE_TO_LEVEL_STATUS_EN adds a saturating droppedCount status output.
module edge_to_level
    import edge_pkg::*;
#(
    parameter int unsigned MIN_HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       risingEdge,
    input  logic       fallingEdge,
    output logic       levelOut,
    output logic       busy,
    output logic       pending
`ifdef EDGE_TO_LEVEL_STATUS_EN
    ,
    output logic [7:0] droppedCount
`endif
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD_CYCLES - 1);

    state_e state_q, state_d;
    logic   pending_q, pending_d;
    logic   level_q, busy_q;
    logic   load_c, dec_c, zero_c;
    logic   rise_c, fall_c;
`ifdef EDGE_TO_LEVEL_STATUS_EN
    logic   cancel_c;
`endif

    // Simultaneous strobes are a glitch and act as neither edge.
    assign rise_c = risingEdge & ~fallingEdge;
    assign fall_c = fallingEdge & ~risingEdge;

    hold_counter #(
        .CNT_W(CNT_W)
    ) u_hold_counter (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load_c),
        .load_val_i(HOLD_LOAD),
        .dec_i     (dec_c),
        .zero_c_o  (zero_c)
    );

    // Strobes update pending first, so expiry sees the strobe of its own cycle.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        load_c    = 1'b0;
        dec_c     = 1'b0;
`ifdef EDGE_TO_LEVEL_STATUS_EN
        cancel_c  = 1'b0;
`endif
        case (state_q)
            LOW_IDLE: begin
                if (rise_c) begin
                    state_d = HOLD_HIGH;
                    load_c  = 1'b1;
                end
            end
            HIGH_IDLE: begin
                if (fall_c) begin
                    state_d = HOLD_LOW;
                    load_c  = 1'b1;
                end
            end
            HOLD_HIGH: begin
                dec_c = ~zero_c;
                if (fall_c) begin
                    pending_d = 1'b1;
                end else if (rise_c && pending_q) begin
                    pending_d = 1'b0;
`ifdef EDGE_TO_LEVEL_STATUS_EN
                    cancel_c  = 1'b1;
`endif
                end
                if (zero_c) begin
                    if (pending_d) begin
                        state_d   = HOLD_LOW;
                        pending_d = 1'b0;
                        load_c    = 1'b1;
                    end else begin
                        state_d = HIGH_IDLE;
                    end
                end
            end
            HOLD_LOW: begin
                dec_c = ~zero_c;
                if (rise_c) begin
                    pending_d = 1'b1;
                end else if (fall_c && pending_q) begin
                    pending_d = 1'b0;
`ifdef EDGE_TO_LEVEL_STATUS_EN
                    cancel_c  = 1'b1;
`endif
                end
                if (zero_c) begin
                    if (pending_d) begin
                        state_d   = HOLD_HIGH;
                        pending_d = 1'b0;
                        load_c    = 1'b1;
                    end else begin
                        state_d = LOW_IDLE;
                    end
                end
            end
            default: begin
                state_d   = LOW_IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOW_IDLE;
            pending_q <= 1'b0;
            level_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            level_q   <= (state_d == HOLD_HIGH) || (state_d == HIGH_IDLE);
            busy_q    <= (state_d == HOLD_HIGH) || (state_d == HOLD_LOW);
        end
    end

    assign levelOut = level_q;
    assign busy     = busy_q;
    assign pending  = pending_q;

`ifdef EDGE_TO_LEVEL_STATUS_EN
    logic [7:0] dropped_q;

    // Counts glitch cycles and cancelled edge pairs, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_q <= 8'd0;
        end else if (((risingEdge & fallingEdge) | cancel_c) && (dropped_q != 8'hFF)) begin
            dropped_q <= dropped_q + 8'd1;
        end
    end

    assign droppedCount = dropped_q;
`else
    // Status counter not present in this build.
`endif

endmodule

// File: tb/tb_edge_to_level.sv
// Self-checking bench for edge_to_level with MIN_HOLD_CYCLES=4.
module tb_edge_to_level;

    localparam int unsigned N     = 4;
    localparam int unsigned CNT_W = 8;

    logic clk = 1'b0;
    logic reset, risingEdge, fallingEdge;
    logic levelOut, busy, pending;
`ifdef EDGE_TO_LEVEL_STATUS_EN
    logic [7:0] droppedCount;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: current level, cycles of hold remaining, queued edge, drop tally.
    logic m_level;
    int   m_left;
    logic m_pend;
    int   m_drop;

    edge_to_level #(
        .MIN_HOLD_CYCLES(N),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .risingEdge (risingEdge),
        .fallingEdge(fallingEdge),
        .levelOut   (levelOut),
        .busy       (busy),
        .pending    (pending)
`ifdef EDGE_TO_LEVEL_STATUS_EN
        ,
        .droppedCount(droppedCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic rise;
        logic fall;
        logic lvl;
        logic bsy;
        logic pnd;
        int   drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rs, logic r, logic f, logic l, logic b, logic p, int d);
        vec_t v;
        v.rst = rs; v.rise = r; v.fall = f; v.lvl = l; v.bsy = b; v.pnd = p; v.drop = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    function automatic int sat(int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_step(input logic rs, input logic r, input logic f);
        logic was_busy;
        if (rs) begin
            m_level = 1'b0; m_left = 0; m_pend = 1'b0; m_drop = 0;
        end else begin
            was_busy = (m_left > 0);
            if (r && f) begin
                m_drop = sat(m_drop + 1);
            end else if (!was_busy) begin
                if (r && !m_level) begin
                    m_level = 1'b1; m_left = N;
                end else if (f && m_level) begin
                    m_level = 1'b0; m_left = N;
                end
            end else begin
                if (m_level ? f : r) begin
                    m_pend = 1'b1;
                end else if ((m_level ? r : f) && m_pend) begin
                    m_pend = 1'b0;
                    m_drop = sat(m_drop + 1);
                end
            end
            if (was_busy) begin
                m_left--;
                if (m_left == 0 && m_pend) begin
                    m_level = ~m_level;
                    m_pend  = 1'b0;
                    m_left  = N;
                end
            end
        end
    endtask

    task automatic do_cycle(input logic rs, input logic r, input logic f);
        reset = rs; risingEdge = r; fallingEdge = f;
        @(posedge clk);
        model_step(rs, r, f);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_level"}, 32'(levelOut), 32'(m_level));
        chk({tag, "_busy"},  32'(busy),     32'(m_left > 0));
        chk({tag, "_pend"},  32'(pending),  32'(m_pend));
`ifdef EDGE_TO_LEVEL_STATUS_EN
        chk({tag, "_drop"},  32'(droppedCount), 32'(m_drop));
`endif
    endtask

    initial begin
        int held;
        reset = 1'b1; risingEdge = 1'b0; fallingEdge = 1'b0;
        m_level = 1'b0; m_left = 0; m_pend = 1'b0; m_drop = 0;

        // Directed vectors: inputs for one cycle, outputs visible after that edge.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0)); // reset
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0)); // rise, latency 1
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0)); // fall queued
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0)); // expiry releases queued fall
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0)); // LOW_IDLE
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1)); // glitch
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1)); // redundant fall
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 2)); // cancel pair
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2)); // HIGH_IDLE, level kept
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 2)); // redundant rise
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0)); // reset mid-hold drops queue
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0)); // fall in expiry cycle
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            do_cycle(tbl[i].rst, tbl[i].rise, tbl[i].fall);
            chk($sformatf("vec%0d_level", i), 32'(levelOut), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d_busy", i),  32'(busy),     32'(tbl[i].bsy));
            chk($sformatf("vec%0d_pend", i),  32'(pending),  32'(tbl[i].pnd));
`ifdef EDGE_TO_LEVEL_STATUS_EN
            chk($sformatf("vec%0d_drop", i),  32'(droppedCount), 32'(tbl[i].drop));
`endif
        end

        // Hold length: busy stays high for exactly N cycles after a rise.
        do_cycle(1, 0, 0);
        do_cycle(0, 1, 0);
        held = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            held++;
            do_cycle(0, 0, 0);
        end
        chk("hold_len", 32'(held), 32'(N));
        chk("hold_level_after", 32'(levelOut), 32'd1);

        // Long glitch run saturates the drop counter and never moves the level.
        do_cycle(1, 0, 0);
        for (int k = 0; k < 300; k++) do_cycle(0, 1, 1);
        chk("glitch_level", 32'(levelOut), 32'd0);
        chk("glitch_busy",  32'(busy),     32'd0);
`ifdef EDGE_TO_LEVEL_STATUS_EN
        chk("glitch_sat", 32'(droppedCount), 32'd255);
`endif

        // Random strobes and occasional resets against the model.
        do_cycle(1, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            do_cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0));
            chk_model($sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
